// File: rtl/mem_dma_engine.sv
// Word-by-word memory copy engine: read a source word, write it to the destination, repeat.
// Optional fill mode (MEM_DMA_ENGINE_FILL_EN) writes a constant pattern with no reads.
module mem_dma_engine #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   src_addr_i,
    input  logic [ADDR_WIDTH-1:0]   dst_addr_i,
    input  logic [LEN_WIDTH-1:0]    len_i,
`ifdef MEM_DMA_ENGINE_FILL_EN
    input  logic                    fill_i,
    input  logic [DATA_WIDTH-1:0]   fill_data_i,
`endif
    output logic                    busy_o,
    output logic                    done_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int unsigned          WB       = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] AddrMask = ~ADDR_WIDTH'(WB - 1);
    localparam logic [ADDR_WIDTH-1:0] AddrStep = ADDR_WIDTH'(WB);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e                 state_q;
    logic [ADDR_WIDTH-1:0]  src_q;
    logic [ADDR_WIDTH-1:0]  dst_q;
    logic [LEN_WIDTH-1:0]   remaining_q;
    logic                   fill_q;
    logic                   fill_start;
    logic [DATA_WIDTH-1:0]  fill_data;
    logic [ADDR_WIDTH-1:0]  src_start;
    logic [ADDR_WIDTH-1:0]  dst_start;

`ifdef MEM_DMA_ENGINE_FILL_EN
    assign fill_start = fill_i;
    assign fill_data  = fill_data_i;
`else
    assign fill_start = 1'b0;
    assign fill_data  = '0;
`endif

    assign src_start = src_addr_i & AddrMask;
    assign dst_start = dst_addr_i & AddrMask;

    // Memory-side outputs are registered and hold the value for the state being entered;
    // mem_wdata_o doubles as the captured data register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            src_q       <= '0;
            dst_q       <= '0;
            remaining_q <= '0;
            fill_q      <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            mem_addr_o  <= '0;
            mem_we_o    <= 1'b0;
            mem_wdata_o <= '0;
            mem_wstrb_o <= '0;
        end else begin
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            mem_addr_o  <= '0;
            mem_we_o    <= 1'b0;
            mem_wdata_o <= '0;
            mem_wstrb_o <= '0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        src_q       <= src_start;
                        dst_q       <= dst_start;
                        remaining_q <= len_i;
                        fill_q      <= fill_start;
                        if (len_i == '0) begin
                            state_q <= StDone;
                            done_o  <= 1'b1;
                        end else if (fill_start) begin
                            state_q     <= StWrite;
                            busy_o      <= 1'b1;
                            mem_addr_o  <= dst_start;
                            mem_we_o    <= 1'b1;
                            mem_wdata_o <= fill_data;
                            mem_wstrb_o <= '1;
                        end else begin
                            state_q    <= StRead;
                            busy_o     <= 1'b1;
                            mem_addr_o <= src_start;
                        end
                    end
                end
                StRead: begin
                    state_q     <= StWrite;
                    busy_o      <= 1'b1;
                    mem_addr_o  <= dst_q;
                    mem_we_o    <= 1'b1;
                    mem_wdata_o <= mem_rdata_i;
                    mem_wstrb_o <= '1;
                end
                StWrite: begin
                    src_q       <= src_q + AddrStep;
                    dst_q       <= dst_q + AddrStep;
                    remaining_q <= remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_q <= StDone;
                        done_o  <= 1'b1;
                    end else if (fill_q) begin
                        state_q     <= StWrite;
                        busy_o      <= 1'b1;
                        mem_addr_o  <= dst_q + AddrStep;
                        mem_we_o    <= 1'b1;
                        mem_wdata_o <= mem_wdata_o;
                        mem_wstrb_o <= '1;
                    end else begin
                        state_q    <= StRead;
                        busy_o     <= 1'b1;
                        mem_addr_o <= src_q + AddrStep;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dma_engine.sv
// Directed bench for mem_dma_engine on an 8-word memory (ADDR_WIDTH=5).
// Fill-mode vectors run only when MEM_DMA_ENGINE_FILL_EN is defined.
module tb_mem_dma_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  src_addr = '0;
    logic [4:0]  dst_addr = '0;
    logic [7:0]  len = '0;
    logic        busy, done, mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
`ifdef MEM_DMA_ENGINE_FILL_EN
    logic        fill = 1'b0;
    logic [31:0] fill_data = '0;
`endif

    logic [31:0] mem [8];
    logic        tb_we = 1'b0;
    logic [2:0]  tb_idx = '0;
    logic [31:0] tb_data = '0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0] waddr [8];
    logic [3:0] wstrb0;
    int         n_writes;
    int         done_at;
    logic       done_busy;

    always #5 clk = ~clk;

    mem_dma_engine #(
        .ADDR_WIDTH(5),
        .DATA_WIDTH(32),
        .LEN_WIDTH (8)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .src_addr_i (src_addr),
        .dst_addr_i (dst_addr),
        .len_i      (len),
`ifdef MEM_DMA_ENGINE_FILL_EN
        .fill_i     (fill),
        .fill_data_i(fill_data),
`endif
        .busy_o     (busy),
        .done_o     (done),
        .mem_addr_o (mem_addr),
        .mem_we_o   (mem_we),
        .mem_wdata_o(mem_wdata),
        .mem_wstrb_o(mem_wstrb),
        .mem_rdata_i(mem_rdata)
    );

    // Behavioural memory: combinational read, byte-strobed write on the rising edge.
    assign mem_rdata = mem[mem_addr[4:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) mem[mem_addr[4:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end else if (tb_we) begin
            mem[tb_idx] <= tb_data;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] data);
        @(negedge clk);
        tb_we   = 1'b1;
        tb_idx  = 3'(idx);
        tb_data = data;
        @(negedge clk);
        tb_we   = 1'b0;
    endtask

    // Words 0..3 = 0x11111111 .. 0x44444444, words 4..7 = 0.
    task automatic preload();
        for (int i = 0; i < 8; i++) poke(i, (i < 4) ? 32'(i + 1) * 32'h1111_1111 : 32'h0);
    endtask

    // Cycle 1 is the cycle right after the start-sampling edge.
    task automatic run_xfer(input logic [4:0] src, input logic [4:0] dst, input logic [7:0] n,
                            input logic fl, input logic [31:0] fd, input int glitch_at,
                            input int rst_at);
        int cyc;
        @(negedge clk);
        start    = 1'b1;
        src_addr = src;
        dst_addr = dst;
        len      = n;
`ifdef MEM_DMA_ENGINE_FILL_EN
        fill      = fl;
        fill_data = fd;
`else
        if (fl || fd != 32'h0) $display("note: fill vector skipped in copy-only build");
`endif
        @(negedge clk);
        start     = 1'b0;
        cyc       = 1;
        n_writes  = 0;
        done_at   = 0;
        done_busy = 1'b0;
        wstrb0    = '0;
        for (int i = 0; i < 8; i++) waddr[i] = '1;
        for (int i = 0; i < 24; i++) begin
            if (mem_we) begin
                if (n_writes < 8) waddr[n_writes] = mem_addr;
                if (n_writes == 0) wstrb0 = mem_wstrb;
                n_writes++;
            end
            if (done) begin
                done_at   = cyc;
                done_busy = busy;
                break;
            end
            start = (cyc == glitch_at);
            if (cyc == glitch_at) begin
                src_addr = 5'h08;
                dst_addr = 5'h00;
                len      = 8'd1;
            end
            rst_n = !(cyc == rst_at);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idle_writes;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'h0);
        check_eq("rst_done", 64'(done), 64'h0);
        check_eq("rst_we", 64'(mem_we), 64'h0);
        check_eq("rst_addr", 64'(mem_addr), 64'h0);
        check_eq("rst_wdata", 64'(mem_wdata), 64'h0);
        check_eq("rst_wstrb", 64'(mem_wstrb), 64'h0);
        idle_writes = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_we || busy) idle_writes++;
            @(negedge clk);
        end
        check_eq("idle_quiet", 64'(idle_writes), 64'h0);

        // Basic copy: words 0,1 -> 2,3.
        preload();
        run_xfer(5'h00, 5'h08, 8'd2, 1'b0, 32'h0, 0, 0);
        check_eq("basic_done_cycle", 64'(done_at), 64'd5);
        check_eq("basic_done_busy", 64'(done_busy), 64'h0);
        check_eq("basic_pulse_len", 64'(done), 64'h0);
        check_eq("basic_writes", 64'(n_writes), 64'd2);
        check_eq("basic_waddr0", 64'(waddr[0]), 64'h08);
        check_eq("basic_waddr1", 64'(waddr[1]), 64'h0C);
        check_eq("basic_wstrb", 64'(wstrb0), 64'hF);
        check_eq("basic_mem2", 64'(mem[2]), 64'h1111_1111);
        check_eq("basic_mem3", 64'(mem[3]), 64'h2222_2222);
        check_eq("basic_mem4", 64'(mem[4]), 64'h0);

        // Zero length: done the very next cycle, no writes.
        run_xfer(5'h00, 5'h10, 8'd0, 1'b0, 32'h0, 0, 0);
        check_eq("zero_done_cycle", 64'(done_at), 64'd1);
        check_eq("zero_writes", 64'(n_writes), 64'd0);
        check_eq("zero_mem4", 64'(mem[4]), 64'h0);

        // Unaligned addresses are truncated to word boundaries.
        preload();
        run_xfer(5'h01, 5'h13, 8'd1, 1'b0, 32'h0, 0, 0);
        check_eq("align_done_cycle", 64'(done_at), 64'd3);
        check_eq("align_waddr0", 64'(waddr[0]), 64'h10);
        check_eq("align_mem4", 64'(mem[4]), 64'h1111_1111);

        // Wrap-around with overlap: 0x18->0x1C, then 0x1C (already overwritten)->0x00.
        preload();
        poke(6, 32'hA6A6_A6A6);
        poke(7, 32'hA7A7_A7A7);
        run_xfer(5'h18, 5'h1C, 8'd2, 1'b0, 32'h0, 0, 0);
        check_eq("wrap_done_cycle", 64'(done_at), 64'd5);
        check_eq("wrap_waddr0", 64'(waddr[0]), 64'h1C);
        check_eq("wrap_waddr1", 64'(waddr[1]), 64'h00);
        check_eq("wrap_mem7", 64'(mem[7]), 64'hA6A6_A6A6);
        check_eq("wrap_mem0", 64'(mem[0]), 64'hA6A6_A6A6);

        // New start with different parameters mid-transfer is ignored.
        preload();
        run_xfer(5'h00, 5'h10, 8'd3, 1'b0, 32'h0, 2, 0);
        check_eq("busy_done_cycle", 64'(done_at), 64'd7);
        check_eq("busy_writes", 64'(n_writes), 64'd3);
        check_eq("busy_mem4", 64'(mem[4]), 64'h1111_1111);
        check_eq("busy_mem5", 64'(mem[5]), 64'h2222_2222);
        check_eq("busy_mem6", 64'(mem[6]), 64'h3333_3333);
        check_eq("busy_mem0", 64'(mem[0]), 64'h1111_1111);
        check_eq("busy_after_idle", 64'(busy), 64'h0);

        // Reset during the second READ: one word lands, no done pulse.
        preload();
        run_xfer(5'h00, 5'h10, 8'd3, 1'b0, 32'h0, 0, 3);
        check_eq("rstmid_done", 64'(done_at), 64'd0);
        check_eq("rstmid_writes", 64'(n_writes), 64'd1);
        check_eq("rstmid_mem4", 64'(mem[4]), 64'h1111_1111);
        check_eq("rstmid_mem5", 64'(mem[5]), 64'h0);
        check_eq("rstmid_busy", 64'(busy), 64'h0);

`ifdef MEM_DMA_ENGINE_FILL_EN
        preload();
        run_xfer(5'h1C, 5'h00, 8'd4, 1'b1, 32'hDEAD_BEEF, 0, 0);
        check_eq("fill_done_cycle", 64'(done_at), 64'd5);
        check_eq("fill_writes", 64'(n_writes), 64'd4);
        check_eq("fill_waddr3", 64'(waddr[3]), 64'h0C);
        for (int i = 0; i < 4; i++) check_eq("fill_mem", 64'(mem[i]), 64'hDEAD_BEEF);
        check_eq("fill_mem4", 64'(mem[4]), 64'h0);
        check_eq("fill_mem7", 64'(mem[7]), 64'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
